rr_chan_mux: RTL and testbench

Parametrised, registered N-to-1 channel multiplexer with a valid/ready handshake on every input and on the output. It runs in one of two modes. Mode 0 is round-robin arbitration among the requesting channels. Mode 1 is fixed selection by `sel`, which is the classic mux behaviour, now registered and flow-controlled. It sits between several producer channels and a single downstream consumer, and is the general replacement for fixed-width combinational 4-to-1 muxes in the datapath.

---
 rtl/rr_chan_mux.sv | 66 ++++++
 tb/tb_rr_chan_mux.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rr_chan_mux.sv
// rr_chan_mux: registered N-to-1 valid/ready channel mux, round-robin (mode=0) or fixed select (mode=1)
// Ports: clk, rst (sync, active-high); mode, sel pick the arbitration policy;
// in_valid/in_data/in_ready are the NCH producer channels (channel i at in_data[i*WIDTH +: WIDTH]);
// out_valid/out_data/out_ch/out_ready form the single registered consumer channel.
module rr_chan_mux #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);
  logic            accept, gv, xfer;
  logic [SELW-1:0] ptr, gidx;
  logic [SELW:0]   idx;
  logic [WIDTH-1:0] gdata;
  // Round-robin scan visits ptr, ptr+1, ... with an explicit modulo so non-power-of-two NCH wraps correctly
  always_comb begin
    gv = 1'b0;
    gidx = '0;
    idx = '0;
    gdata = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = {1'b0, ptr} + (SELW+1)'(k);
      idx = idx >= (SELW+1)'(NCH) ? idx - (SELW+1)'(NCH) : idx;
      for (int c = 0; c < NCH; c++)
        if (!mode && !gv && idx == (SELW+1)'(c) && in_valid[c]) begin
          gv = 1'b1;
          gidx = SELW'(c);
        end
      if (mode && sel == SELW'(k) && in_valid[k]) begin
        gv = 1'b1;
        gidx = sel;
      end
    end
    for (int k = 0; k < NCH; k++)
      if (gidx == SELW'(k)) gdata = in_data[k*WIDTH +: WIDTH];
  end
  assign accept   = !out_valid || out_ready;
  assign xfer     = accept && gv && !rst;
  assign in_ready = xfer ? NCH'(1) << gidx : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gdata;
      out_ch    <= gidx;
      ptr       <= gidx == SELW'(NCH-1) ? '0 : gidx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_chan_mux.sv
// tb_rr_chan_mux: scoreboard bench driving a 4x8 and a 3x16 rr_chan_mux with shared stimulus
module tb_rr_chan_mux;
  logic        clk = 1'b0, rst = 1'b1, mode = 1'b0, out_ready = 1'b1;
  logic [1:0]  sel = '0;
  logic [3:0]  iv = '0;
  logic [15:0] d [4];
  logic [3:0]  ir_a;
  logic [2:0]  ir_b;
  logic        ov_a, ov_b;
  logic [7:0]  od_a;
  logic [15:0] od_b;
  logic [1:0]  oc_a, oc_b;
  logic [31:0] in_data_a;
  logic [47:0] in_data_b;
  int nchk = 0, nfail = 0;
  int mp [2];
  bit mov [2];
  logic [17:0] sb [2][$];

  always #5 clk = ~clk;

  assign in_data_a = {d[3][7:0], d[2][7:0], d[1][7:0], d[0][7:0]};
  assign in_data_b = {d[2], d[1], d[0]};

  rr_chan_mux #(.NCH(4), .WIDTH(8), .SELW(2)) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_valid(iv), .in_data(in_data_a),
    .in_ready(ir_a), .out_valid(ov_a), .out_data(od_a), .out_ch(oc_a), .out_ready(out_ready));

  rr_chan_mux #(.NCH(3), .WIDTH(16), .SELW(2)) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_valid(iv[2:0]), .in_data(in_data_b),
    .in_ready(ir_b), .out_valid(ov_b), .out_data(od_b), .out_ch(oc_b), .out_ready(out_ready));

  function automatic int exp_grant(int n, int p);
    if (mode) return (int'(sel) < n && iv[sel]) ? int'(sel) : -1;
    for (int k = 0; k < n; k++) if (iv[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction

  // Called right after a negedge with inputs already driven; checks, then advances one clock
  task automatic step();
    int g [2];
    bit xf [2];
    #2;
    for (int u = 0; u < 2; u++) begin
      int n = u ? 3 : 4;
      logic [3:0] em, o_ir;
      logic o_ov;
      logic [17:0] o_w;
      o_ir = u ? {1'b0, ir_b} : ir_a;
      o_ov = u ? ov_b : ov_a;
      o_w  = u ? {oc_b, od_b} : {oc_a, 8'h00, od_a};
      g[u] = exp_grant(n, mp[u]);
      xf[u] = (!mov[u] || out_ready) && g[u] >= 0 && !rst;
      em = xf[u] ? 4'(1 << g[u]) : 4'h0;
      nchk++;
      if (o_ir !== em) begin
        nfail++;
        $display("FAIL in_ready dut%0d t=%0t: got %b expected %b", u, $time, o_ir, em);
      end
      nchk++;
      if (o_ov !== mov[u]) begin
        nfail++;
        $display("FAIL out_valid dut%0d t=%0t: got %b expected %b", u, $time, o_ov, mov[u]);
      end
      if (mov[u] && sb[u].size() > 0) begin
        nchk++;
        if (o_w !== sb[u][0]) begin
          nfail++;
          $display("FAIL out_word dut%0d t=%0t: got ch=%0d data=%h expected ch=%0d data=%h",
                   u, $time, o_w[17:16], o_w[15:0], sb[u][0][17:16], sb[u][0][15:0]);
        end
      end
    end
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        mov[u] = 1'b0;
        mp[u] = 0;
        sb[u].delete();
      end else begin
        if (mov[u] && out_ready) void'(sb[u].pop_front());
        if (xf[u]) begin
          sb[u].push_back({2'(g[u]), d[g[u]] & (u ? 16'hFFFF : 16'h00FF)});
          mov[u] = 1'b1;
          mp[u] = (g[u] + 1) % (u ? 3 : 4);
        end else if (out_ready) mov[u] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; iv = 4'hF; mode = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 16'h1100 + 16'(i);
    repeat (2) begin
      step();
      nchk++;
      if ({od_a, oc_a, od_b, oc_b} !== 28'h0) begin
        nfail++;
        $display("FAIL reset_out: got %h/%0d %h/%0d expected zeros", od_a, oc_a, od_b, oc_b);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    mode = 1'b0; iv = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 16'hB0A0 + 16'(i);
    repeat (10) step();
  endtask

  task automatic test_sparse();
    iv = 4'b0011;
    repeat (4) step();
  endtask

  task automatic test_back_pressure();
    mode = 1'b1; sel = 2'd0; iv = 4'b0001; d[0] = 16'h905C; out_ready = 1'b1;
    step();
    out_ready = 1'b0; d[0] = 16'h9077;
    repeat (3) begin
      step();
      nchk++;
      if (od_a !== 8'h5C) begin
        nfail++;
        $display("FAIL stall_hold: got %h expected 5c", od_a);
      end
    end
    out_ready = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_fixed_select();
    mode = 1'b1; sel = 2'd2; iv = 4'hF; d[2] = 16'h4433; out_ready = 1'b1;
    repeat (4) step();
    iv = 4'b1011;
    repeat (3) step();
    sel = 2'd3; iv = 4'hF;
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    mode = 1'b0; iv = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 16'hC000 + 16'(i * 16'h0101);
    repeat (7) step();
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_random();
    repeat (60) begin
      mode = 1'($urandom_range(0, 3) == 0);
      sel = 2'($urandom);
      iv = 4'($urandom);
      out_ready = 1'($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) d[i] = '0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_sparse();
    test_back_pressure();
    test_fixed_select();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
